// File: rtl/uart_reg_bridge_if.sv
// Bus bundle between the UART byte port, the internal register bus and
// the bridge status outputs.
interface uart_reg_bridge_if;
  logic       uart_valid;
  logic [7:0] uart_rx_data;
  logic       uart_read;
  logic       uart_busy;
  logic       uart_write;
  logic [7:0] uart_tx_data;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       frame_active;
  logic [7:0] error_count;

  modport master (
    input  uart_valid, uart_rx_data, uart_busy, reg_rdata,
    output uart_read, uart_write, uart_tx_data, reg_addr, reg_wdata,
           reg_we, reg_re, frame_active, error_count
  );

  modport slave (
    output uart_valid, uart_rx_data, uart_busy, reg_rdata,
    input  uart_read, uart_write, uart_tx_data, reg_addr, reg_wdata,
           reg_we, reg_re, frame_active, error_count
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// UART command bridge: parses 'W' addr data / 'R' addr frames, drives the
// register bus and returns a single response byte.
module uart_reg_bridge #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input logic               clk,
  input logic               reset,
  uart_reg_bridge_if.master bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_ADDR = 3'd1;
  localparam logic [2:0] GET_DATA = 3'd2;
  localparam logic [2:0] REG_WR   = 3'd3;
  localparam logic [2:0] REG_RD   = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] SEND     = 3'd6;

  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_NG = 8'h3F;

  logic [2:0]  state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  tx_q, tx_d;
  logic        is_wr_q, is_wr_d;
  logic        rd_last_q;
  logic        intake, tmo_hit, take, err_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign intake  = (state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign tmo_hit = ((state_q == GET_ADDR) || (state_q == GET_DATA)) && (tmo_q == TIMEOUT);
  // rd_last_q keeps uart_read from firing back-to-back while the UART updates uart_valid.
  assign take    = intake && bus.uart_valid && !rd_last_q && !tmo_hit && !reset;

  // Frame parser, timeout counter and response selection.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    is_wr_d = is_wr_q;
    err_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          if (bus.uart_rx_data == CMD_W || bus.uart_rx_data == CMD_R) begin
            is_wr_d = (bus.uart_rx_data == CMD_W);
            tmo_d   = 16'd0;
            state_d = GET_ADDR;
          end else begin
            tx_d    = RSP_NG;
            err_inc = 1'b1;
            state_d = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (tmo_hit) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else if (take) begin
          addr_d  = bus.uart_rx_data;
          tmo_d   = 16'd0;
          state_d = is_wr_q ? GET_DATA : REG_RD;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      GET_DATA: begin
        if (tmo_hit) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else if (take) begin
          wdata_d = bus.uart_rx_data;
          tmo_d   = 16'd0;
          state_d = REG_WR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      REG_WR: begin
        tx_d    = RSP_OK;
        state_d = SEND;
      end
      REG_RD:  state_d = RD_WAIT;
      RD_WAIT: begin
        tx_d    = bus.reg_rdata;
        state_d = SEND;
      end
      SEND: begin
        if (!bus.uart_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_inc ? sat_inc(err_q) : err_q;
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tmo_q     <= 16'd0;
      err_q     <= 8'd0;
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      tx_q      <= 8'd0;
      is_wr_q   <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      is_wr_q   <= is_wr_d;
      rd_last_q <= take;
    end
  end

  assign bus.uart_read    = take;
  assign bus.uart_write   = (state_q == SEND) && !bus.uart_busy && !reset;
  assign bus.reg_we       = (state_q == REG_WR) && !reset;
  assign bus.reg_re       = (state_q == REG_RD) && !reset;
  assign bus.uart_tx_data = tx_q;
  assign bus.reg_addr     = addr_q;
  assign bus.reg_wdata    = wdata_q;
  assign bus.frame_active = (state_q != IDLE);
  assign bus.error_count  = err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: expected register events and
// response bytes are queued by the stimulus and checked by a monitor.
module tb_uart_reg_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  typedef struct packed {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } reg_ev_t;

  reg_ev_t    exp_reg[$];
  logic [7:0] exp_tx[$];
  logic [7:0] mem [256];

  uart_reg_bridge_if bus ();

  uart_reg_bridge #(.TIMEOUT(16'd100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file model: read data appears the cycle after reg_re.
  always @(posedge clk) begin
    if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    bus.uart_valid   = 1'b1;
    bus.uart_rx_data = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.uart_read) break;
      n++;
      if (n > 2000) break;
    end
    if (n > 2000) fail_now("byte_not_read");
    @(posedge clk); #1;
    bus.uart_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_reg.size() != 0 || bus.frame_active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("wait_idle_timeout");
  endtask

  task automatic push_reg(input logic w, input logic [7:0] a, input logic [7:0] d);
    reg_ev_t e;
    e.is_wr = w;
    e.addr  = a;
    e.data  = d;
    exp_reg.push_back(e);
  endtask

  initial begin
    bus.uart_valid   = 1'b0;
    bus.uart_rx_data = 8'h00;
    bus.uart_busy    = 1'b0;
    bus.reg_rdata    = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h34] = 8'h5C;
    mem[8'h10] = 8'h77;
    mem[8'h20] = 8'h99;

    fork
      begin : monitor
        logic    prev_read;
        reg_ev_t e;
        logic [7:0] t;
        prev_read = 1'b0;
        forever begin
          @(negedge clk);
          if (!reset) begin
            if (bus.uart_read && prev_read) fail_now("uart_read_back_to_back");
            if (bus.uart_write) begin
              if (bus.uart_busy) fail_now("write_while_busy");
              if (exp_tx.size() == 0) fail_now("unexpected_uart_write");
              else begin
                t = exp_tx.pop_front();
                check8("tx_byte", bus.uart_tx_data, t);
              end
            end
            if (bus.reg_we || bus.reg_re) begin
              if (exp_reg.size() == 0) fail_now("unexpected_reg_strobe");
              else begin
                e = exp_reg.pop_front();
                check8("reg_kind_we", {7'd0, bus.reg_we}, {7'd0, e.is_wr});
                check8("reg_addr", bus.reg_addr, e.addr);
                if (e.is_wr) check8("reg_wdata", bus.reg_wdata, e.data);
              end
            end
          end
          prev_read = bus.uart_read;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check8("rst_uart_write", {7'd0, bus.uart_write}, 8'd0);
    check8("rst_reg_we", {7'd0, bus.reg_we}, 8'd0);
    check8("rst_reg_re", {7'd0, bus.reg_re}, 8'd0);
    check8("rst_frame_active", {7'd0, bus.frame_active}, 8'd0);
    check8("rst_error_count", bus.error_count, 8'd0);
    check8("rst_tx_data", bus.uart_tx_data, 8'd0);
    check8("rst_reg_addr", bus.reg_addr, 8'd0);

    // Write frame
    push_reg(1'b1, 8'h12, 8'hA5);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h12); send_byte(8'hA5);
    wait_idle();
    check8("wr_mem", mem[8'h12], 8'hA5);
    check8("wr_err", bus.error_count, 8'd0);

    // Read frame
    push_reg(1'b0, 8'h34, 8'h00);
    exp_tx.push_back(8'h5C);
    send_byte(8'h52); send_byte(8'h34);
    wait_idle();
    check8("rd_addr_hold", bus.reg_addr, 8'h34);

    // Timeout after a partial write frame
    send_byte(8'h57); send_byte(8'h10);
    repeat (150) @(negedge clk);
    check8("tmo_frame_active", {7'd0, bus.frame_active}, 8'd0);
    check8("tmo_err", bus.error_count, 8'd1);
    push_reg(1'b0, 8'h10, 8'h00);
    exp_tx.push_back(8'h77);
    send_byte(8'h52); send_byte(8'h10);
    wait_idle();

    // Busy stall at SEND
    bus.uart_busy = 1'b1;
    push_reg(1'b1, 8'h40, 8'h3C);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h40); send_byte(8'h3C);
    repeat (500) @(negedge clk);
    check8("busy_frame_active", {7'd0, bus.frame_active}, 8'd1);
    check8("busy_tx_pending", bus.uart_tx_data, 8'h4B);
    check8("busy_tx_queued", 8'(exp_tx.size()), 8'd1);
    @(posedge clk); #1 bus.uart_busy = 1'b0;
    wait_idle();

    // Reset in the middle of a frame
    send_byte(8'h57); send_byte(8'h20);
    @(negedge clk);
    check8("mid_frame_active", {7'd0, bus.frame_active}, 8'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check8("mid_rst_frame_active", {7'd0, bus.frame_active}, 8'd0);
    check8("mid_rst_err", bus.error_count, 8'd0);
    push_reg(1'b0, 8'h20, 8'h00);
    exp_tx.push_back(8'h99);
    send_byte(8'h52); send_byte(8'h20);
    wait_idle();
    check8("mid_rst_mem_untouched", mem[8'h20], 8'h99);

    // Unknown commands up to saturation
    exp_tx.push_back(8'h3F);
    send_byte(8'h00);
    wait_idle();
    check8("unk_err_1", bus.error_count, 8'd1);
    for (int i = 1; i < 300; i++) begin
      exp_tx.push_back(8'h3F);
      send_byte(8'h00);
      wait_idle();
    end
    check8("unk_err_sat", bus.error_count, 8'hFF);

    repeat (5) @(negedge clk);
    check8("end_tx_queue_empty", 8'(exp_tx.size()), 8'd0);
    check8("end_reg_queue_empty", 8'(exp_reg.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
